// File: rtl/rf_wb_pkg.sv
// Shared types and default sizes for the register-file write-back scheduler.
package rf_wb_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned NUM_REQ    = 3;
   localparam int unsigned NUM_REGS   = 32;

   typedef enum logic {WB_IDLE, WB_WRITE} wb_state_e;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr (wrapping) wins, one-hot grant.
module rr_arbiter #(
   parameter int unsigned N = 3,
   localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]    req,
   input  logic [PtrW-1:0] ptr,
   output logic [N-1:0]    grant
);

   logic [PtrW-1:0] idx;

   always_comb begin
      grant = '0;
      idx   = '0;
      for (int unsigned i = 0; i < N; i++) begin
         idx = PtrW'((32'(ptr) + i) % N);
         if (req[idx] && (grant == '0)) begin
            grant[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Write-back scheduler: arbitrates the register-file write port and keeps the busy scoreboard.
// Optional operand bypass during the write cycle is enabled with `define WB_BYPASS_EN.
module rf_wb_scheduler
   import rf_wb_pkg::*;
#(
   parameter int unsigned XLEN       = rf_wb_pkg::XLEN,
   parameter int unsigned NUM_REQ    = rf_wb_pkg::NUM_REQ,
   parameter int unsigned REG_ADDR_W = rf_wb_pkg::REG_ADDR_W
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*REG_ADDR_W-1:0] req_rd,
   input  logic [NUM_REQ*XLEN-1:0]       req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          issue_valid,
   input  logic [REG_ADDR_W-1:0]         issue_rd,
   output logic                          issue_accept,
   input  logic [REG_ADDR_W-1:0]         rs1,
   input  logic [REG_ADDR_W-1:0]         rs2,
   output logic                          rs1_busy,
   output logic                          rs2_busy,
   output logic                          rs1_fwd_hit,
   output logic                          rs2_fwd_hit,
   output logic [XLEN-1:0]               fwd_data,
   output logic                          rf_wr_en,
   output logic [REG_ADDR_W-1:0]         rf_rd,
   output logic [XLEN-1:0]               rf_wr_data,
   output logic [NUM_REGS-1:0]           busy_vec
);

   localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   wb_state_e           state_q, state_d;
   logic [PtrW-1:0]     ptr_q, ptr_d;
   wb_req_t             wb_q, wb_d;
   logic [NUM_REGS-1:0] busy_q, busy_d;
   logic [NUM_REQ-1:0]  grant;
   logic [PtrW-1:0]     win_idx;
   wb_req_t             win_req;

   rr_arbiter #(
      .N (NUM_REQ)
   ) u_arb (
      .req   (req_valid),
      .ptr   (ptr_q),
      .grant (grant)
   );

   always_comb begin
      win_idx = '0;
      win_req = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            win_idx      = PtrW'(i);
            win_req.rd   = req_rd[i*REG_ADDR_W +: REG_ADDR_W];
            win_req.data = req_data[i*XLEN +: XLEN];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      wb_d      = wb_q;
      req_ready = '0;
      unique case (state_q)
         WB_IDLE: begin
            // Grants are hidden while in reset so no handshake is lost.
            if (!rst) req_ready = grant;
            if (grant != '0) begin
               state_d = WB_WRITE;
               wb_d    = win_req;
               ptr_d   = (32'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
            end
         end
         WB_WRITE: state_d = WB_IDLE;
      endcase
   end

   assign issue_accept = !busy_q[issue_rd] || (issue_rd == '0);

   // Clear first, then set, so an issue to the register being written keeps it busy.
   always_comb begin
      busy_d = busy_q;
      if (state_q == WB_WRITE) busy_d[wb_q.rd] = 1'b0;
      if (issue_valid && issue_accept && (issue_rd != '0)) busy_d[issue_rd] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= WB_IDLE;
         ptr_q   <= '0;
         wb_q    <= '0;
         busy_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         wb_q    <= wb_d;
         busy_q  <= busy_d;
      end
   end

   assign rf_wr_en   = (state_q == WB_WRITE) && (wb_q.rd != '0);
   assign rf_rd      = wb_q.rd;
   assign rf_wr_data = wb_q.data;
   assign busy_vec   = busy_q;

`ifdef WB_BYPASS_EN
   assign rs1_fwd_hit = rf_wr_en && (rs1 == wb_q.rd);
   assign rs2_fwd_hit = rf_wr_en && (rs2 == wb_q.rd);
   assign fwd_data    = (state_q == WB_WRITE) ? wb_q.data : '0;
`else
   assign rs1_fwd_hit = 1'b0;
   assign rs2_fwd_hit = 1'b0;
   assign fwd_data    = '0;
`endif

   assign rs1_busy = busy_q[rs1] && !rs1_fwd_hit;
   assign rs2_busy = busy_q[rs2] && !rs2_fwd_hit;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed bench for rf_wb_scheduler; build with +define+WB_BYPASS_EN to cover the bypass.
module tb_rf_wb_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req_valid;
   logic [14:0] req_rd;
   logic [95:0] req_data;
   logic [2:0]  req_ready;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic        issue_accept;
   logic [4:0]  rs1, rs2;
   logic        rs1_busy, rs2_busy, rs1_fwd_hit, rs2_fwd_hit;
   logic [31:0] fwd_data;
   logic        rf_wr_en;
   logic [4:0]  rf_rd;
   logic [31:0] rf_wr_data;
   logic [31:0] busy_vec;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   rf_wb_scheduler dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_rd       (req_rd),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .issue_valid  (issue_valid),
      .issue_rd     (issue_rd),
      .issue_accept (issue_accept),
      .rs1          (rs1),
      .rs2          (rs2),
      .rs1_busy     (rs1_busy),
      .rs2_busy     (rs2_busy),
      .rs1_fwd_hit  (rs1_fwd_hit),
      .rs2_fwd_hit  (rs2_fwd_hit),
      .fwd_data     (fwd_data),
      .rf_wr_en     (rf_wr_en),
      .rf_rd        (rf_rd),
      .rf_wr_data   (rf_wr_data),
      .busy_vec     (busy_vec)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic prev_wr;
      int   w;

      rst = 1'b1; req_valid = '0; req_rd = '0; req_data = '0;
      issue_valid = 1'b0; issue_rd = '0; rs1 = '0; rs2 = '0;

      // 1. reset and idle
      tick();
      chk("rst_wr_en", 32'(rf_wr_en), 32'd0);
      chk("rst_busy", busy_vec, 32'd0);
      chk("rst_rd", 32'(rf_rd), 32'd0);
      chk("rst_data", rf_wr_data, 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("idle_wr_en", 32'(rf_wr_en), 32'd0);
         chk("idle_busy", busy_vec, 32'd0);
      end

      // 2. issue rd=5, then LSU writes rd=5
      issue_valid = 1'b1; issue_rd = 5'd5;
      #1 chk("t2_accept", 32'(issue_accept), 32'd1);
      tick();
      issue_valid = 1'b0;
      chk("t2_busy_set", busy_vec, 32'h0000_0020);
      rs1 = 5'd5; rs2 = 5'd5;
      #1 chk("t2_rs1_busy_idle", 32'(rs1_busy), 32'd1);
      req_valid = 3'b010; req_rd[5 +: 5] = 5'd5; req_data[32 +: 32] = 32'hDEAD_BEEF;
      #1 chk("t2_ready", 32'(req_ready), 32'd2);
      tick();
      req_valid = '0;
      chk("t2_wr_en", 32'(rf_wr_en), 32'd1);
      chk("t2_rd", 32'(rf_rd), 32'd5);
      chk("t2_data", rf_wr_data, 32'hDEAD_BEEF);
      chk("t2_ready_write", 32'(req_ready), 32'd0);
`ifdef WB_BYPASS_EN
      chk("t2_rs1_hit", 32'(rs1_fwd_hit), 32'd1);
      chk("t2_rs2_hit", 32'(rs2_fwd_hit), 32'd1);
      chk("t2_fwd_data", fwd_data, 32'hDEAD_BEEF);
      chk("t2_rs1_busy_write", 32'(rs1_busy), 32'd0);
`else
      chk("t2_rs1_hit", 32'(rs1_fwd_hit), 32'd0);
      chk("t2_fwd_data", fwd_data, 32'd0);
      chk("t2_rs1_busy_write", 32'(rs1_busy), 32'd1);
`endif
      tick();
      chk("t2_wr_low", 32'(rf_wr_en), 32'd0);
      chk("t2_busy_clr", busy_vec, 32'd0);
      chk("t2_rs1_busy_after", 32'(rs1_busy), 32'd0);

      // 4. rd=0 from MDU (pointer now 2): granted, no write pulse
      req_valid = 3'b100; req_rd[10 +: 5] = 5'd0; req_data[64 +: 32] = 32'h0000_1234;
      #1 chk("t4_ready", 32'(req_ready), 32'd4);
      tick();
      req_valid = '0;
      chk("t4_wr_en", 32'(rf_wr_en), 32'd0);
      chk("t4_busy", busy_vec, 32'd0);
      tick();
      chk("t4_wr_en_after", 32'(rf_wr_en), 32'd0);

      // 3. all requesters valid continuously (pointer back at 0)
      req_rd = {5'd3, 5'd2, 5'd1};
      req_data = {32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0};
      req_valid = 3'b111;
      prev_wr = 1'b0;
      #1;
      for (int k = 0; k < 8; k++) begin
         w = (k / 2) % 3;
         if (k % 2 == 0) begin
            chk("t3_grant", 32'(req_ready), 32'(1 << w));
            chk("t3_wr_idle", 32'(rf_wr_en), 32'd0);
         end else begin
            chk("t3_ready_write", 32'(req_ready), 32'd0);
            chk("t3_wr_en", 32'(rf_wr_en), 32'd1);
            chk("t3_rd", 32'(rf_rd), 32'(w + 1));
            chk("t3_data", rf_wr_data, 32'(32'hA0 + w));
         end
         chk("t3_no_b2b", 32'(prev_wr & rf_wr_en), 32'd0);
         prev_wr = rf_wr_en;
         tick();
         #1;
      end
      req_valid = '0;

      // 5. WAW stall, then set-wins when issue hits the register being written
      issue_valid = 1'b1; issue_rd = 5'd7;
      #1 chk("t5_accept_free", 32'(issue_accept), 32'd1);
      tick();
      chk("t5_busy7", busy_vec, 32'h0000_0080);
      #1 chk("t5_accept_stall", 32'(issue_accept), 32'd0);
      req_valid = 3'b001; req_rd[0 +: 5] = 5'd7; req_data[0 +: 32] = 32'd77;
      #1 chk("t5_ready_a", 32'(req_ready), 32'd1);
      tick();
      req_valid = '0; issue_valid = 1'b0;
      chk("t5_busy_still", busy_vec, 32'h0000_0080);
      tick();
      chk("t5_busy_cleared", busy_vec, 32'd0);
      req_valid = 3'b001; req_data[0 +: 32] = 32'd88;
      #1 chk("t5_ready_b", 32'(req_ready), 32'd1);
      tick();
      req_valid = '0;
      issue_valid = 1'b1; issue_rd = 5'd7;
      #1 chk("t5_accept_write", 32'(issue_accept), 32'd1);
      chk("t5_wr_en", 32'(rf_wr_en), 32'd1);
      tick();
      issue_valid = 1'b0;
      chk("t5_set_wins", busy_vec, 32'h0000_0080);

      // 6. reset during WRITE drops the write and clears the scoreboard
      issue_valid = 1'b1; issue_rd = 5'd9;
      tick();
      issue_valid = 1'b0;
      chk("t6_busy_pre", busy_vec, 32'h0000_0280);
      req_valid = 3'b010; req_rd[5 +: 5] = 5'd9; req_data[32 +: 32] = 32'd99;
      #1 chk("t6_ready", 32'(req_ready), 32'd2);
      tick();
      req_valid = '0;
      chk("t6_wr_en", 32'(rf_wr_en), 32'd1);
      rst = 1'b1;
      tick();
      chk("t6_wr_dropped", 32'(rf_wr_en), 32'd0);
      chk("t6_busy_clr", busy_vec, 32'd0);
      chk("t6_rd_clr", 32'(rf_rd), 32'd0);
      rst = 1'b0;
      tick();
      chk("t6_wr_after", 32'(rf_wr_en), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
